// File: rtl/rx_crc_chk_20b_if.sv
// Receive word stream into the CRC-10 checker: one 20-bit word per valid
// cycle, with first-payload-word and CRC-word qualifiers.
interface rx_crc_chk_20b_if;
  logic [19:0] data_in;
  logic        data_vld;
  logic        sof;
  logic        eof;

  // Upstream deserializer side drives the stream.
  modport master (output data_in, data_vld, sof, eof);
  // Checker side consumes it.
  modport slave  (input  data_in, data_vld, sof, eof);
endinterface

// File: rtl/rx_crc_chk_20b.sv
// Receive-side CRC-10 checker for the 20-bit SerDes word stream.
// Accumulates CRC-10 (x^10+x^9+x^5+x^4+x+1, seed 0, no final XOR) over the
// payload words of each frame and compares it against the CRC word that
// ends the frame. Reports one-cycle pass / fail / framing pulses and keeps
// saturating pass and error counters.
module rx_crc_chk_20b #(
  parameter int MAX_WORDS = 64,  // payload words per frame, CRC word excluded
  parameter int CHK_RSVD  = 1,   // 1: CRC word bits [19:10] must be zero
  parameter int CNT_W     = 16   // statistics counter width
) (
  input  logic             clk,
  input  logic             rst_n,
  rx_crc_chk_20b_if.slave  rx,
  input  logic             cnt_clr,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             frm_err,
  output logic [9:0]       crc_calc,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int                WCNT_W     = $clog2(MAX_WORDS + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX   = WCNT_W'(MAX_WORDS);
  localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);
  localparam logic [9:0]        CRC10_POLY = 10'h233;  // x^10 term implicit
  localparam bit                RSVD_CHK   = (CHK_RSVD != 0);

  typedef enum logic {
    ST_IDLE,
    ST_ACC
  } state_t;

  // 20-bit parallel CRC-10 update, MSB of the word shifted in first.
  // Must stay bit-identical to the TX generator's next-state function;
  // check vector: crc10_d20(10'h000, 20'h00001) == 10'h233.
  function automatic logic [9:0] crc10_d20(input logic [9:0] crc, input logic [19:0] d);
    logic [9:0] c;
    logic       fb;
    // NOTE: blocking assignments here (and in always_comb) because each
    // step reads the value produced by the previous one; state registers
    // below use non-blocking assignments only.
    c = crc;
    for (int i = 19; i >= 0; i--) begin
      fb = c[9] ^ d[i];
      c  = {c[8:0], 1'b0};
      if (fb) c = c ^ CRC10_POLY;
    end
    return c;
  endfunction

  state_t            r_state;
  logic [9:0]        r_crc;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_crc_ok;
  logic              r_crc_err;
  logic              r_frm_err;
  logic [CNT_W-1:0]  r_ok_cnt;
  logic [CNT_W-1:0]  r_err_cnt;

  state_t            w_state_nxt;
  logic [9:0]        w_crc_nxt;
  logic [WCNT_W-1:0] w_wcnt_nxt;
  logic              w_ok_nxt;
  logic              w_err_nxt;
  logic              w_frm_nxt;
  logic [9:0]        w_crc_seed;
  logic [9:0]        w_crc_step;
  logic              w_rsvd_ok;
  logic              w_crc_match;

  // CRC of a fresh first word, and CRC of the running frame plus this word.
  assign w_crc_seed  = crc10_d20(10'h000, rx.data_in);
  assign w_crc_step  = crc10_d20(r_crc, rx.data_in);
  // The CRC word carries the accumulated payload CRC in [9:0]; the upper
  // field is reserved and optionally required to be zero.
  assign w_rsvd_ok   = !RSVD_CHK || (rx.data_in[19:10] == 10'h000);
  assign w_crc_match = (rx.data_in[9:0] == r_crc) && w_rsvd_ok;

  // Frame state, CRC accumulator, word count and result pulses.
  // NOTE: asynchronous active-low reset; every register here is a plain
  // flop, so all of them are cleared by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_crc     <= 10'h000;
      r_wcnt    <= '0;
      r_crc_ok  <= 1'b0;
      r_crc_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_crc     <= w_crc_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_crc_ok  <= w_ok_nxt;
      r_crc_err <= w_err_nxt;
      r_frm_err <= w_frm_nxt;
    end
  end

  // Next-state decode: frame start, accumulate, compare, framing aborts.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_crc_nxt   = r_crc;
    w_wcnt_nxt  = r_wcnt;
    w_ok_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    w_frm_nxt   = 1'b0;

    if (rx.data_vld) begin
      unique case (r_state)
        ST_IDLE: begin
          if (rx.eof) begin
            // CRC word with no payload in front of it (also sof & eof).
            w_frm_nxt = 1'b1;
          end else if (rx.sof) begin
            w_crc_nxt   = w_crc_seed;
            w_wcnt_nxt  = WCNT_ONE;
            w_state_nxt = ST_ACC;
          end
          // Unflagged words outside a frame are dropped.
        end

        ST_ACC: begin
          if (rx.sof) begin
            // New frame start aborts the running one. With eof also set the
            // word is an empty frame: discarded without a second error.
            w_frm_nxt = 1'b1;
            if (rx.eof) begin
              w_crc_nxt   = 10'h000;
              w_wcnt_nxt  = '0;
              w_state_nxt = ST_IDLE;
            end else begin
              w_crc_nxt  = w_crc_seed;
              w_wcnt_nxt = WCNT_ONE;
            end
          end else if (rx.eof) begin
            // Compare against the payload CRC, not one that includes the
            // CRC word itself.
            w_ok_nxt    = w_crc_match;
            w_err_nxt   = !w_crc_match;
            w_crc_nxt   = 10'h000;
            w_wcnt_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end else if (r_wcnt == WCNT_MAX) begin
            // One payload word too many: frame is discarded.
            w_frm_nxt   = 1'b1;
            w_crc_nxt   = 10'h000;
            w_wcnt_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_crc_nxt  = w_crc_step;
            w_wcnt_nxt = r_wcnt + WCNT_ONE;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Saturating statistics, driven by the registered result pulses;
  // a clear wins over an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ok_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (cnt_clr) begin
      r_ok_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (r_crc_ok && !(&r_ok_cnt)) begin
        r_ok_cnt <= r_ok_cnt + 1'b1;
      end
      if ((r_crc_err || r_frm_err) && !(&r_err_cnt)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign crc_ok   = r_crc_ok;
  assign crc_err  = r_crc_err;
  assign frm_err  = r_frm_err;
  assign crc_calc = r_crc;
  assign ok_cnt   = r_ok_cnt;
  assign err_cnt  = r_err_cnt;

  // Result pulses never overlap, and the word count never passes the limit.
  a_pulse_excl: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({r_crc_ok, r_crc_err, r_frm_err}));
  a_wcnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    r_wcnt <= WCNT_MAX);

endmodule

// File: tb/tb_rx_crc_chk_20b.sv
// Bench for rx_crc_chk_20b. Two builds receive the same word stream:
//   A: MAX_WORDS=64, CHK_RSVD=1, CNT_W=16
//   B: MAX_WORDS=4,  CHK_RSVD=0, CNT_W=4
// The reference model keeps each frame's payload words and derives the
// expected CRC by textbook GF(2) long division of the whole payload
// bitstream (times x^10) by the generator polynomial.
module tb_rx_crc_chk_20b;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cnt_clr = 1'b0;

  always #5 clk = ~clk;

  rx_crc_chk_20b_if if_a ();
  rx_crc_chk_20b_if if_b ();

  logic        a_ok, a_err, a_frm, b_ok, b_err, b_frm;
  logic [9:0]  a_crc, b_crc;
  logic [15:0] a_okc, a_errc;
  logic [3:0]  b_okc, b_errc;

  rx_crc_chk_20b #(.MAX_WORDS(64), .CHK_RSVD(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(if_a.slave), .cnt_clr(cnt_clr),
    .crc_ok(a_ok), .crc_err(a_err), .frm_err(a_frm), .crc_calc(a_crc),
    .ok_cnt(a_okc), .err_cnt(a_errc));

  rx_crc_chk_20b #(.MAX_WORDS(4), .CHK_RSVD(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(if_b.slave), .cnt_clr(cnt_clr),
    .crc_ok(b_ok), .crc_err(b_err), .frm_err(b_frm), .crc_calc(b_crc),
    .ok_cnt(b_okc), .err_cnt(b_errc));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (index 0 = A, 1 = B) ----------------
  int          p_maxw[2] = '{64, 4};
  bit          p_rsvd[2] = '{1'b1, 1'b0};
  int          p_cmax[2] = '{65535, 15};

  bit          m_in[2];
  int          m_n[2];
  logic [19:0] m_pay[2][0:1023];
  bit          e_ok[2], e_err[2], e_frm[2], e_known[2];
  int          e_okc[2], e_errc[2];

  // Remainder of (payload bitstream * x^10) mod P(x), MSB of first word first.
  function automatic logic [9:0] poly_rem(input logic [19:0] words[$]);
    logic [10:0] poly;
    logic [9:0]  r;
    bit          msg[];
    int          len;
    poly = 11'h633;
    len  = 20 * words.size() + 10;
    msg  = new[len];
    foreach (words[w]) begin
      for (int b = 0; b < 20; b++) msg[20 * w + b] = words[w][19 - b];
    end
    for (int i = 0; i < len - 10; i++) begin
      if (msg[i]) begin
        for (int j = 0; j <= 10; j++) msg[i + j] = msg[i + j] ^ poly[10 - j];
      end
    end
    for (int j = 0; j < 10; j++) r[9 - j] = msg[len - 10 + j];
    return r;
  endfunction

  function automatic logic [9:0] model_crc(input int k);
    logic [19:0] q[$];
    for (int i = 0; i < m_n[k]; i++) q.push_back(m_pay[k][i]);
    return poly_rem(q);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_in[k] = 0; m_n[k] = 0; e_ok[k] = 0; e_err[k] = 0; e_frm[k] = 0;
      e_okc[k] = 0; e_errc[k] = 0; e_known[k] = 1;
    end
  endtask

  // Predicts the outputs after the next clock edge for the given inputs.
  task automatic model_step(input int k, input bit vld, input bit sof, input bit eof,
                            input logic [19:0] d, input bit clr);
    logic [9:0] want;
    if (clr) begin
      e_okc[k] = 0; e_errc[k] = 0;
    end else begin
      if (e_ok[k] && e_okc[k] < p_cmax[k]) e_okc[k]++;
      if ((e_err[k] || e_frm[k]) && e_errc[k] < p_cmax[k]) e_errc[k]++;
    end
    e_ok[k] = 0; e_err[k] = 0; e_frm[k] = 0;
    if (vld) begin
      if (!m_in[k]) begin
        if (eof) e_frm[k] = 1;
        else if (sof) begin
          m_in[k] = 1; m_n[k] = 1; m_pay[k][0] = d;
        end
      end else if (sof) begin
        e_frm[k] = 1;
        if (eof) begin
          m_in[k] = 0; e_known[k] = 0;
        end else begin
          m_n[k] = 1; m_pay[k][0] = d;
        end
      end else if (eof) begin
        want = model_crc(k);
        if (d[9:0] == want && (!p_rsvd[k] || d[19:10] == 10'h0)) e_ok[k] = 1;
        else e_err[k] = 1;
        m_in[k] = 0; e_known[k] = 1;
      end else if (m_n[k] == p_maxw[k]) begin
        e_frm[k] = 1; m_in[k] = 0; e_known[k] = 0;
      end else begin
        m_pay[k][m_n[k]] = d; m_n[k]++;
      end
    end
  endtask

  task automatic check_one(input int k, input logic ok, input logic err, input logic frm,
                           input logic [9:0] crc, input logic [31:0] okc, input logic [31:0] errc);
    string p;
    p = (k == 0) ? "A" : "B";
    check({p, "_crc_ok"},  {31'd0, ok},  {31'd0, e_ok[k]});
    check({p, "_crc_err"}, {31'd0, err}, {31'd0, e_err[k]});
    check({p, "_frm_err"}, {31'd0, frm}, {31'd0, e_frm[k]});
    check({p, "_ok_cnt"},  okc,  e_okc[k]);
    check({p, "_err_cnt"}, errc, e_errc[k]);
    if (m_in[k])         check({p, "_crc_calc"}, {22'd0, crc}, {22'd0, model_crc(k)});
    else if (e_known[k]) check({p, "_crc_calc"}, {22'd0, crc}, 32'd0);
  endtask

  // One clock: drive both builds, advance the model, check just after the edge.
  task automatic cyc(input bit vld, input bit sof, input bit eof,
                     input logic [19:0] d, input bit clr);
    if_a.data_vld = vld; if_a.sof = sof; if_a.eof = eof; if_a.data_in = d;
    if_b.data_vld = vld; if_b.sof = sof; if_b.eof = eof; if_b.data_in = d;
    cnt_clr = clr;
    model_step(0, vld, sof, eof, d, clr);
    model_step(1, vld, sof, eof, d, clr);
    @(posedge clk);
    #1;
    check_one(0, a_ok, a_err, a_frm, a_crc, {16'd0, a_okc}, {16'd0, a_errc});
    check_one(1, b_ok, b_err, b_frm, b_crc, {28'd0, b_okc}, {28'd0, b_errc});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 20'h0, 1'b0);
  endtask

  task automatic rnd_phase(input int n, input int clr_rate);
    bit          vld, sof, eof, clr;
    int          r, k;
    logic [19:0] d;
    for (int i = 0; i < n; i++) begin
      vld = ($urandom_range(0, 9) < 7);
      r   = $urandom_range(0, 15);
      sof = (r == 0);
      eof = (r == 1) || (r == 2);
      d   = 20'($urandom);
      k   = $urandom_range(0, 1);
      if (eof && m_in[k] && $urandom_range(0, 3) != 0) begin
        d[9:0]   = model_crc(k);
        d[19:10] = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'h0;
      end
      clr = (clr_rate != 0) && ($urandom_range(0, clr_rate - 1) == 0);
      cyc(vld, sof, eof, d, clr);
    end
  endtask

  logic [19:0] w0, w1, w2;
  logic [19:0] q3[$];
  logic [9:0]  c3;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    if_a.data_vld = 0; if_a.sof = 0; if_a.eof = 0; if_a.data_in = '0;
    if_b.data_vld = 0; if_b.sof = 0; if_b.eof = 0; if_b.data_in = '0;
    model_reset();
    #12;
    check("rst_a_outputs", {a_ok, a_err, a_frm, a_crc, a_okc, a_errc}, 32'd0);
    check("rst_b_outputs", {19'd0, b_ok, b_err, b_frm, b_crc}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Single-word frame, check vector f(0, 1) = 0x233.
    cyc(1, 1, 0, 20'h00001, 0);
    check("tp_crc_calc_233", {22'd0, a_crc}, 32'h233);
    cyc(1, 0, 1, 20'h00233, 0);
    check("tp_single_ok", {31'd0, a_ok}, 32'd1);
    idle(1);
    check("tp_ok_cnt_1", {16'd0, a_okc}, 32'd1);

    // Wrong CRC.
    cyc(1, 1, 0, 20'h00001, 0);
    cyc(1, 0, 1, 20'h00232, 0);
    check("tp_bad_crc_err", {31'd0, a_err}, 32'd1);
    idle(1);
    check("tp_err_cnt_1", {16'd0, a_errc}, 32'd1);

    // Reserved bit set: fails with CHK_RSVD=1 (A), passes with 0 (B).
    cyc(1, 1, 0, 20'h00001, 0);
    cyc(1, 0, 1, 20'h00633, 0);
    check("tp_rsvd_a_err", {31'd0, a_err}, 32'd1);
    check("tp_rsvd_b_ok", {31'd0, b_ok}, 32'd1);
    idle(1);

    // 3-word frame, gap-free and with 2-cycle gaps.
    w0 = 20'hABCDE; w1 = 20'h12345; w2 = 20'hFFFFF;
    q3 = '{w0, w1, w2};
    c3 = poly_rem(q3);
    cyc(1, 1, 0, w0, 0); cyc(1, 0, 0, w1, 0); cyc(1, 0, 0, w2, 0);
    cyc(1, 0, 1, {10'h0, c3}, 0);
    check("tp_3w_ok", {31'd0, a_ok}, 32'd1);
    cyc(1, 1, 0, w0, 0); idle(2); cyc(1, 0, 0, w1, 0); idle(2); cyc(1, 0, 0, w2, 0);
    check("tp_3w_gap_crc", {22'd0, a_crc}, {22'd0, c3});
    cyc(1, 0, 1, {10'h0, c3}, 0);
    check("tp_3w_gap_ok", {31'd0, a_ok}, 32'd1);

    // sof on word 2 aborts; the new frame then passes.
    q3 = '{w1, w2};
    cyc(1, 1, 0, w0, 0);
    cyc(1, 1, 0, w1, 0);
    check("tp_resof_frm", {31'd0, a_frm}, 32'd1);
    cyc(1, 0, 0, w2, 0);
    cyc(1, 0, 1, {10'h0, poly_rem(q3)}, 0);
    check("tp_resof_ok", {31'd0, a_ok}, 32'd1);

    // eof in IDLE, then sof & eof on one word.
    cyc(1, 0, 1, 20'h00000, 0);
    check("tp_idle_eof_frm", {31'd0, a_frm}, 32'd1);
    cyc(1, 1, 1, 20'h00001, 0);
    check("tp_sofeof_frm", {31'd0, a_frm}, 32'd1);

    // Five payload words: B (MAX_WORDS=4) overflows, then sees eof in IDLE.
    q3 = '{20'h11111, 20'h22222, 20'h33333, 20'h44444, 20'h55555};
    cyc(1, 1, 0, q3[0], 0);
    for (int i = 1; i < 5; i++) cyc(1, 0, 0, q3[i], 0);
    check("tp_max_b_frm", {31'd0, b_frm}, 32'd1);
    cyc(1, 0, 1, {10'h0, poly_rem(q3)}, 0);
    check("tp_max_b_eof_frm", {31'd0, b_frm}, 32'd1);
    check("tp_max_a_ok", {31'd0, a_ok}, 32'd1);
    idle(1);
    check("tp_b_err_cnt_6", {28'd0, b_errc}, 32'd6);

    // cnt_clr in the same cycle as crc_ok.
    cyc(1, 1, 0, 20'h00001, 0);
    cyc(1, 0, 1, 20'h00233, 0);
    cyc(0, 0, 0, 20'h0, 1);
    check("tp_clr_vs_ok", {16'd0, a_okc}, 32'd0);
    idle(1);

    // Random traffic without clears: B's 4-bit error counter must saturate.
    rnd_phase(2000, 0);
    check("tp_b_err_sat", {28'd0, b_errc}, 32'hF);
    // Random traffic with occasional clears.
    rnd_phase(2000, 16);
    idle(2);

    // Asynchronous reset in the middle of a frame.
    cyc(1, 1, 0, 20'h00001, 0);
    cyc(1, 0, 0, 20'h00002, 0);
    rst_n = 1'b0;
    #1;
    check("tp_rst_mid_a", {a_ok, a_err, a_frm, a_crc, a_okc, a_errc}, 32'd0);
    check("tp_rst_mid_b", {19'd0, b_ok, b_err, b_frm, b_crc}, 32'd0);
    check("tp_rst_mid_bcnt", {24'd0, b_okc, b_errc}, 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    // The eof of the discarded frame must now be a framing error.
    cyc(1, 0, 1, 20'h00233, 0);
    check("tp_rst_eof_frm", {31'd0, a_frm}, 32'd1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
